gpio_in_cond: RTL and testbench

Input-conditioning stage directly upstream of the GPIO register block. Takes raw asynchronous pad inputs, synchronises and debounces them, and drives the clean vector into the GPIO block's i_gpio. Also detects per-pin rising and falling edges into a Wishbone-accessible pending register and drives a level interrupt. Sits on the same Wishbone peripheral bus as the GPIO block, in its own address slot.

---
 rtl/gpio_in_pkg.sv | 26 ++
 rtl/gpio_debounce_bit.sv | 66 ++++++
 rtl/gpio_in_cond.sv | 145 ++++++++++++++
 tb/tb_gpio_in_cond.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_in_pkg.sv
// Shared constants for the GPIO input-conditioning block: register offsets,
// default debounce depth / prescaler width, and a byte-lane mask helper.
package gpio_in_pkg;

  // Register offsets, decoded from wb_adr_i[3:2]
  localparam logic [1:0] GPIO_IN_PRESCALE = 2'd0;
  localparam logic [1:0] GPIO_IN_RISE_EN  = 2'd1;
  localparam logic [1:0] GPIO_IN_FALL_EN  = 2'd2;
  localparam logic [1:0] GPIO_IN_PENDING  = 2'd3;

  // Default number of equal samples needed to accept a new level
  localparam int GPIO_IN_DEB_N = 3;
  // Default prescaler width in bits
  localparam int GPIO_IN_PW    = 16;

  // Expand the 4 Wishbone byte selects into a 32-bit bit mask
  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      m[i*8 +: 8] = {8{sel[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// One pin of input conditioning: two-flop synchroniser, tick-paced sample
// shifter, and the accepted (stable) level with its rise/fall strobes.
// rise/fall are combinational and fire in the cycle before stable changes,
// so the pending register can latch them on the same edge as stable.
module gpio_debounce_bit
  import gpio_in_pkg::*;
#(
  parameter int DEB_N = GPIO_IN_DEB_N
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic pad,
  output logic stable,
  output logic rise,
  output logic fall
);

  logic             s1;
  logic             s2;
  logic [DEB_N-1:0] sh;
  logic             stable_next;

  // Two-flop synchroniser for the asynchronous pad
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= pad;
      s2 <= s1;
    end
  end

  // Shift in one synchronised sample per prescaler tick
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh <= '0;
    end else if (tick) begin
      sh <= {sh[DEB_N-2:0], s2};
    end
  end

  // Accept a new level only when every sample in the window agrees
  always_comb begin
    stable_next = stable;
    if (&sh) begin
      stable_next = 1'b1;
    end else if (~|sh) begin
      stable_next = 1'b0;
    end
  end

  // Accepted level register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stable <= 1'b0;
    end else begin
      stable <= stable_next;
    end
  end

  assign rise = stable_next & ~stable;
  assign fall = ~stable_next & stable;

endmodule

// File: rtl/gpio_in_cond.sv
// GPIO input conditioning: per-pin synchronise + debounce feeding the GPIO
// block's i_gpio, with per-pin edge detection into a W1C pending register
// and a registered level interrupt. Wishbone slave with four registers.
//
// Bus handshake: a transfer happens in any cycle where wb_cyc_i & wb_stb_i
// is high; wb_ack_o is that same AND (zero wait states), a write commits on
// the clock edge that ends the cycle when wb_we_i is also high, and
// wb_dat_o is a pure function of wb_adr_i[3:2] and register state.
module gpio_in_cond
  import gpio_in_pkg::*;
#(
  parameter int GW    = 32,
  parameter int DEB_N = GPIO_IN_DEB_N,
  parameter int PW    = GPIO_IN_PW
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic          wb_we_i,
  input  logic [3:0]    wb_adr_i,
  input  logic [31:0]   wb_dat_i,
  input  logic [3:0]    wb_sel_i,
  output logic [31:0]   wb_dat_o,
  output logic          wb_ack_o,
  input  logic [GW-1:0] pad_i,
  output logic [GW-1:0] gpio_in_o,
  output logic          irq_o
);

  logic [PW-1:0] prescale;
  logic [PW-1:0] cnt;
  logic          tick;
  logic [GW-1:0] rise_en;
  logic [GW-1:0] fall_en;
  logic [GW-1:0] pending;
  logic [GW-1:0] pending_next;
  logic [GW-1:0] rise_vec;
  logic [GW-1:0] fall_vec;
  logic [GW-1:0] clr_vec;

  logic          bus_wr;
  logic [1:0]    reg_sel;
  logic [31:0]   wmask;
  logic          wr_prescale;
  logic          wr_rise_en;
  logic          wr_fall_en;
  logic          wr_pending;
  logic          adr_unused;

  assign wb_ack_o   = wb_cyc_i & wb_stb_i;
  assign bus_wr     = wb_cyc_i & wb_stb_i & wb_we_i;
  assign reg_sel    = wb_adr_i[3:2];
  assign wmask      = byte_mask(wb_sel_i);
  assign adr_unused = ^wb_adr_i[1:0];

  // Register write strobes
  always_comb begin
    wr_prescale = bus_wr && (reg_sel == GPIO_IN_PRESCALE);
    wr_rise_en  = bus_wr && (reg_sel == GPIO_IN_RISE_EN);
    wr_fall_en  = bus_wr && (reg_sel == GPIO_IN_FALL_EN);
    wr_pending  = bus_wr && (reg_sel == GPIO_IN_PENDING);
  end

  // Control registers with per-byte-lane write merge
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      prescale <= '0;
      rise_en  <= '0;
      fall_en  <= '0;
    end else begin
      if (wr_prescale) begin
        prescale <= PW'((32'(prescale) & ~wmask) | (wb_dat_i & wmask));
      end
      if (wr_rise_en) begin
        rise_en <= GW'((32'(rise_en) & ~wmask) | (wb_dat_i & wmask));
      end
      if (wr_fall_en) begin
        fall_en <= GW'((32'(fall_en) & ~wmask) | (wb_dat_i & wmask));
      end
    end
  end

  // A PRESCALE write restarts the count and suppresses that cycle's tick
  always_comb begin
    tick = (cnt == prescale) && !wr_prescale;
  end

  // Prescaler counter 0..PRESCALE
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      cnt <= '0;
    end else if (wr_prescale || (cnt == prescale)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PW'(1);
    end
  end

  for (genvar i = 0; i < GW; i++) begin : g_pin
    gpio_debounce_bit #(.DEB_N(DEB_N)) u_bit (
      .clk    (wb_clk_i),
      .rst_n  (wb_rst_i),
      .tick   (tick),
      .pad    (pad_i[i]),
      .stable (gpio_in_o[i]),
      .rise   (rise_vec[i]),
      .fall   (fall_vec[i])
    );
  end

  // Pending update: clear first, then OR in new edges so a set wins
  always_comb begin
    clr_vec = '0;
    if (wr_pending) begin
      clr_vec = GW'(wb_dat_i & wmask);
    end
    pending_next = (pending & ~clr_vec)
                 | (rise_vec & rise_en)
                 | (fall_vec & fall_en);
  end

  // Pending register and registered interrupt
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      pending <= '0;
      irq_o   <= 1'b0;
    end else begin
      pending <= pending_next;
      irq_o   <= |pending;
    end
  end

  // Zero-extended read mux
  always_comb begin
    wb_dat_o = '0;
    case (reg_sel)
      GPIO_IN_PRESCALE: wb_dat_o = 32'(prescale);
      GPIO_IN_RISE_EN:  wb_dat_o = 32'(rise_en);
      GPIO_IN_FALL_EN:  wb_dat_o = 32'(fall_en);
      default:          wb_dat_o = 32'(pending);
    endcase
  end

endmodule

// File: tb/tb_gpio_in_cond.sv
// Bench for gpio_in_cond: register table, directed latency/glitch/edge
// sequences, then random pads and W1C traffic against a history-window model.
module tb_gpio_in_cond;

  localparam int GW    = 32;
  localparam int DEB_N = 3;
  localparam int PW    = 16;

  logic          wb_clk_i;
  logic          wb_rst_i;
  logic          wb_cyc_i;
  logic          wb_stb_i;
  logic          wb_we_i;
  logic [3:0]    wb_adr_i;
  logic [31:0]   wb_dat_i;
  logic [3:0]    wb_sel_i;
  logic [31:0]   wb_dat_o;
  logic          wb_ack_o;
  logic [GW-1:0] pad_i;
  logic [GW-1:0] gpio_in_o;
  logic          irq_o;

  int checks = 0;
  int errors = 0;

  gpio_in_cond #(.GW(GW), .DEB_N(DEB_N), .PW(PW)) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .wb_cyc_i  (wb_cyc_i),
    .wb_stb_i  (wb_stb_i),
    .wb_we_i   (wb_we_i),
    .wb_adr_i  (wb_adr_i),
    .wb_dat_i  (wb_dat_i),
    .wb_sel_i  (wb_sel_i),
    .wb_dat_o  (wb_dat_o),
    .wb_ack_o  (wb_ack_o),
    .pad_i     (pad_i),
    .gpio_in_o (gpio_in_o),
    .irq_o     (irq_o)
  );

  // Clock
  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  // Safety net against a hang
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at +1 after an edge; leaves at +1 after the next (write) edge
  task automatic wb_write(input logic [1:0] r, input logic [31:0] d, input logic [3:0] s);
    wb_adr_i = {r, 2'b00};
    wb_dat_i = d;
    wb_sel_i = s;
    wb_we_i  = 1'b1;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    @(posedge wb_clk_i); #1;
    wb_we_i  = 1'b0;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
  endtask

  // Combinational read inside the current cycle
  task automatic wb_read(input logic [1:0] r, output logic [31:0] d);
    wb_adr_i = {r, 2'b00};
    wb_we_i  = 1'b0;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    #1;
    d = wb_dat_o;
    check("read_ack", {31'b0, wb_ack_o}, 32'd1);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge wb_clk_i); #1;
    end
  endtask

  typedef struct {
    logic [1:0]  reg_idx;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[7];
  logic [31:0] rd;
  logic        seen;

  // Reference model state
  logic [31:0] pad_q[$];
  logic [31:0] stable_m, pend_m, ren_m, fen_m, clr_m;
  logic [31:0] ones, zeros, new_m, rise_m, fall_m;
  logic        irq_m;

  initial begin
    // Register table: cumulative write then readback
    vecs[0] = '{2'd0, 32'hFFFF_FFFF, 4'b1111, 32'h0000_FFFF};
    vecs[1] = '{2'd0, 32'h0000_1200, 4'b0001, 32'h0000_FF00};
    vecs[2] = '{2'd1, 32'h0000_AB00, 4'b0010, 32'h0000_AB00};
    vecs[3] = '{2'd1, 32'h1234_5678, 4'b1000, 32'h1200_AB00};
    vecs[4] = '{2'd2, 32'hA5A5_A5A5, 4'b0101, 32'h00A5_00A5};
    vecs[5] = '{2'd2, 32'hFFFF_FFFF, 4'b0000, 32'h00A5_00A5};
    vecs[6] = '{2'd3, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0000};

    // Reset
    wb_rst_i = 1'b0;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    wb_adr_i = '0;
    wb_dat_i = '0;
    wb_sel_i = '0;
    pad_i    = '0;
    repeat (3) @(posedge wb_clk_i);
    #1;
    wb_rst_i = 1'b1;

    check("reset_gpio", gpio_in_o, 32'h0);
    check("reset_irq", {31'b0, irq_o}, 32'h0);
    for (int r = 0; r < 4; r++) begin
      wb_read(2'(r), rd);
      check($sformatf("reset_reg%0d", r), rd, 32'h0);
    end

    // Table-driven register access
    step(1);
    for (int i = 0; i < 7; i++) begin
      wb_write(vecs[i].reg_idx, vecs[i].dat, vecs[i].sel);
      wb_read(vecs[i].reg_idx, rd);
      check($sformatf("table%0d", i), rd, vecs[i].exp);
      step(1);
    end

    // Test 1: latency with PRESCALE=0, rises not enabled
    wb_write(2'd0, 32'h0, 4'hF);
    wb_write(2'd1, 32'h0, 4'hF);
    wb_write(2'd2, 32'h0, 4'hF);
    step(2);
    pad_i = 32'h1;
    for (int k = 0; k < 8; k++) begin
      @(posedge wb_clk_i); #1;
      check($sformatf("lat_edge%0d", k), {31'b0, gpio_in_o[0]}, (k >= 5) ? 32'd1 : 32'd0);
    end
    wb_read(2'd3, rd);
    check("t1_pending", rd, 32'h0);
    check("t1_irq", {31'b0, irq_o}, 32'h0);

    // Test 2: enabled rise sets pending, irq one edge later, W1C clears
    step(1);
    wb_write(2'd1, 32'h1, 4'hF);
    pad_i = 32'h0;
    step(10);
    wb_adr_i = 4'hC;
    pad_i = 32'h1;
    for (int k = 0; k < 8; k++) begin
      @(posedge wb_clk_i); #1;
      check($sformatf("t2_pend_edge%0d", k), wb_dat_o, (k >= 5) ? 32'd1 : 32'd0);
      check($sformatf("t2_irq_edge%0d", k), {31'b0, irq_o}, (k >= 6) ? 32'd1 : 32'd0);
    end
    wb_write(2'd3, 32'h1, 4'hF);
    check("t2_w1c_pend", wb_dat_o, 32'h0);
    check("t2_w1c_irq_hold", {31'b0, irq_o}, 32'h1);
    step(1);
    check("t2_irq_fall", {31'b0, irq_o}, 32'h0);

    // Test 3: glitch rejection with PRESCALE=4
    wb_write(2'd0, 32'd4, 4'hF);
    seen = 1'b0;
    pad_i[3] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge wb_clk_i); #1;
      seen |= gpio_in_o[3];
    end
    pad_i[3] = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(posedge wb_clk_i); #1;
      seen |= gpio_in_o[3];
    end
    check("t3_short_pulse", {31'b0, seen}, 32'h0);
    seen = 1'b0;
    pad_i[3] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge wb_clk_i); #1;
      seen |= gpio_in_o[3];
    end
    pad_i[3] = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(posedge wb_clk_i); #1;
      seen |= gpio_in_o[3];
    end
    check("t3_long_pulse", {31'b0, seen}, 32'h1);
    wb_write(2'd0, 32'h0, 4'hF);
    step(12);
    check("t3_settled", gpio_in_o, 32'h1);
    wb_read(2'd3, rd);
    check("t3_disabled_no_pend", rd, 32'h0);

    // Test 4: fall-only enable on pin 31
    step(1);
    wb_write(2'd1, 32'h0, 4'hF);
    wb_write(2'd2, 32'h8000_0000, 4'hF);
    pad_i[31] = 1'b1;
    step(10);
    wb_read(2'd3, rd);
    check("t4_rise_ignored", rd, 32'h0);
    pad_i[31] = 1'b0;
    step(10);
    wb_read(2'd3, rd);
    check("t4_fall_pend", rd, 32'h8000_0000);
    check("t4_irq", {31'b0, irq_o}, 32'h1);
    step(1);
    wb_write(2'd2, 32'h0, 4'hF);
    step(2);
    wb_read(2'd3, rd);
    check("t4_en_clear_keeps", rd, 32'h8000_0000);
    step(1);
    wb_write(2'd2, 32'h8000_0000, 4'hF);
    pad_i[31] = 1'b1;
    step(10);
    wb_read(2'd3, rd);
    check("t4_rise_unchanged", rd, 32'h8000_0000);
    step(1);
    wb_write(2'd3, 32'h8000_0000, 4'hF);
    wb_read(2'd3, rd);
    check("t4_w1c", rd, 32'h0);
    step(2);
    check("t4_irq_low", {31'b0, irq_o}, 32'h0);

    // Test 5: W1C on the same edge as a new enabled rise
    wb_write(2'd2, 32'h0, 4'hF);
    wb_write(2'd1, 32'h20, 4'hF);
    pad_i[5] = 1'b1;
    step(10);
    wb_read(2'd3, rd);
    check("t5_first_rise", rd, 32'h20);
    pad_i[5] = 1'b0;
    step(10);
    wb_read(2'd3, rd);
    check("t5_fall_disabled", rd, 32'h20);
    pad_i[5] = 1'b1;
    step(5);
    wb_write(2'd3, 32'h20, 4'hF);
    check("t5_set_wins", wb_dat_o, 32'h20);
    check("t5_irq", {31'b0, irq_o}, 32'h1);
    step(1);
    check("t5_irq_stays", {31'b0, irq_o}, 32'h1);
    wb_write(2'd3, 32'h20, 4'hF);
    check("t5_plain_w1c", wb_dat_o, 32'h0);
    step(1);
    check("t5_irq_low", {31'b0, irq_o}, 32'h0);

    // Test 6: reset mid-debounce
    wb_write(2'd1, 32'hFFFF_FFFF, 4'hF);
    pad_i = 32'h8000_0F21;
    step(10);
    check("t6_pre_gpio", gpio_in_o, 32'h8000_0F21);
    check("t6_pre_irq", {31'b0, irq_o}, 32'h1);
    wb_write(2'd0, 32'd3, 4'hF);
    wb_write(2'd2, 32'hFFFF_FFFF, 4'hF);
    pad_i = 32'h00FF_0000;
    step(6);
    wb_rst_i = 1'b0;
    @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b1;
    check("t6_gpio", gpio_in_o, 32'h0);
    check("t6_irq", {31'b0, irq_o}, 32'h0);
    for (int r = 0; r < 4; r++) begin
      wb_read(2'(r), rd);
      check($sformatf("t6_reg%0d", r), rd, 32'h0);
    end
    for (int k = 1; k <= 5; k++) begin
      @(posedge wb_clk_i); #1;
      check($sformatf("t6_redeb%0d", k), gpio_in_o, 32'h0);
    end
    @(posedge wb_clk_i); #1;
    check("t6_accept", gpio_in_o, 32'h00FF_0000);

    // Random phase: pads, enables and W1C against the window model
    ren_m = $urandom;
    fen_m = $urandom;
    wb_write(2'd1, ren_m, 4'hF);
    wb_write(2'd2, fen_m, 4'hF);
    step(10);
    wb_adr_i = 4'hC;
    stable_m = pad_i;
    pend_m   = '0;
    irq_m    = 1'b0;
    pad_q    = {};
    repeat (DEB_N + 3) pad_q.push_back(pad_i);
    for (int n = 0; n < 400; n++) begin
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_we_i  = 1'b0;
      clr_m    = '0;
      if ($urandom_range(0, 3) == 0) pad_i ^= ($urandom & $urandom & $urandom);
      if ($urandom_range(0, 7) == 0) begin
        clr_m    = $urandom;
        wb_dat_i = clr_m;
        wb_sel_i = 4'hF;
        wb_we_i  = 1'b1;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
      end
      pad_q.push_back(pad_i);
      if (pad_q.size() > 16) void'(pad_q.pop_front());
      @(posedge wb_clk_i); #1;
      // Level accepted when the DEB_N samples ending 3 edges back agree
      irq_m = |pend_m;
      ones  = '1;
      zeros = '1;
      for (int j = 3; j <= 2 + DEB_N; j++) begin
        ones  &= pad_q[pad_q.size() - 1 - j];
        zeros &= ~pad_q[pad_q.size() - 1 - j];
      end
      new_m    = (stable_m | ones) & ~zeros;
      rise_m   = new_m & ~stable_m;
      fall_m   = ~new_m & stable_m;
      pend_m   = (pend_m & ~clr_m) | (rise_m & ren_m) | (fall_m & fen_m);
      stable_m = new_m;
      check($sformatf("rnd_gpio%0d", n), gpio_in_o, stable_m);
      check($sformatf("rnd_irq%0d", n), {31'b0, irq_o}, {31'b0, irq_m});
      check($sformatf("rnd_pend%0d", n), wb_dat_o, pend_m);
    end
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
